// File: rtl/writeback_queue_if.sv
// Producer-to-queue writeback handshake bundle.
// A result transfers on a rising edge where wb_valid and wb_ready are both 1;
// the producer holds address/data stable while wb_valid is high and not yet accepted,
// and wb_ready depends only on the queue's registered state.
interface writeback_queue_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_address;
  logic [15:0] wb_data;

  modport master (output wb_valid, output wb_address, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_address, input wb_data, output wb_ready);
endinterface

// File: rtl/writeback_queue.sv
// FIFO of pending register-file writebacks with pending-register mask and read bypass.
// Optional macro WB_BYPASS_EN builds the bypass lookup; otherwise bypass outputs are tied to 0.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  writeback_queue_if.slave         wb,
  input  logic                     drain_hold_i,
  output logic [15:0]              data_write_o,
  output logic [2:0]               data_write_address_o,
  output logic                     reg_write_enable_o,
  output logic [7:0]               pending_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  input  logic [2:0]               lookup_address0_i,
  input  logic [2:0]               lookup_address1_i,
  output logic                     bypass_hit0_o,
  output logic                     bypass_hit1_o,
  output logic [15:0]              bypass_data0_o,
  output logic [15:0]              bypass_data1_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    addr_q  [DEPTH];
  logic [15:0]   data_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic accept, enqueue, drain;

  assign wb.wb_ready = (count_q < CW'(DEPTH));
  assign accept      = wb.wb_valid && wb.wb_ready;
  // Writes to r0 complete the handshake but never occupy an entry.
  assign enqueue     = accept && (wb.wb_address != 3'd0);
  assign drain       = (count_q != '0) && !drain_hold_i;

  assign reg_write_enable_o   = drain;
  assign data_write_o         = drain ? data_q[rd_ptr_q] : 16'd0;
  assign data_write_address_o = drain ? addr_q[rd_ptr_q] : 3'd0;
  assign occupancy_o          = count_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 3'd0;
        data_q[i] <= 16'd0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (drain) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      // Enqueue never targets the head slot being drained: it needs a free slot.
      if (enqueue) begin
        addr_q[wr_ptr_q]  <= wb.wb_address;
        data_q[wr_ptr_q]  <= wb.wb_data;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      case ({enqueue, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    pending_o = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending_o[addr_q[i]] = 1'b1;
    end
    pending_o[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  logic [AW-1:0] idx;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    bypass_hit0_o  = 1'b0;
    bypass_hit1_o  = 1'b0;
    bypass_data0_o = 16'd0;
    bypass_data1_o = 16'd0;
    idx            = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + AW'(k);
      if (valid_q[idx] && (lookup_address0_i != 3'd0) && (addr_q[idx] == lookup_address0_i)) begin
        bypass_hit0_o  = 1'b1;
        bypass_data0_o = data_q[idx];
      end
      if (valid_q[idx] && (lookup_address1_i != 3'd0) && (addr_q[idx] == lookup_address1_i)) begin
        bypass_hit1_o  = 1'b1;
        bypass_data1_o = data_q[idx];
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup  = ^{lookup_address0_i, lookup_address1_i};
  assign bypass_hit0_o  = 1'b0;
  assign bypass_hit1_o  = 1'b0;
  assign bypass_data0_o = 16'd0;
  assign bypass_data1_o = 16'd0;
`endif

endmodule
